// File: rtl/apo_noc_pkg.sv
// Shared constants for the 5-node circulant C(5; 1, 2) router.
//   N2         packet width, bit N2-1 is the valid/emulation flag
//   VALID_BIT  index of the valid flag
//   PORT_*     input port indices as seen by the arbiter
//   PORT_W     width of a port index
package apo_noc_pkg;

   localparam int N2        = 7;
   localparam int VALID_BIT = N2 - 1;
   localparam int NUM_PORTS = 5;
   localparam int PORT_W    = 3;

   localparam logic [PORT_W-1:0] PORT_FREE = 3'd0;
   localparam logic [PORT_W-1:0] PORT_R1R  = 3'd1;
   localparam logic [PORT_W-1:0] PORT_R2R  = 3'd2;
   localparam logic [PORT_W-1:0] PORT_R1L  = 3'd3;
   localparam logic [PORT_W-1:0] PORT_R2L  = 3'd4;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_HOLD  = 1'b1
   } out_state_e;

endpackage

// File: rtl/apo_port_fifo.sv
// DEPTH-entry synchronous FIFO for one arbiter input.
//   clk, rst_n   clock, async active-low reset (flushes the buffer)
//   i_push       write i_data; accepted when not full, or full with a pop this cycle
//   i_pop        remove the head; ignored when empty
//   i_data       write data
//   o_data       head entry (undefined while empty)
//   o_full       count == DEPTH
//   o_empty      count == 0
module apo_port_fifo
   import apo_noc_pkg::*;
#(
   parameter int W     = 7,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_cnt == CNT_W'(DEPTH));
   assign o_empty   = (r_cnt == '0);
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   // A pop on a full buffer frees the slot being written this same edge.
   assign w_do_push = i_push & (~o_full | w_do_pop);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/apo_port_arbiter_5_nodes.sv
// Input-side scheduler: buffers the five router inputs and hands one packet
// at a time to the routing core, round-robin, over valid/ready.
//   clk, rst_n                 clock, async active-low reset
//   in_free/r1R/r2R/r1L/r2L    input words, ports 0..4; bit N2-1 = valid
//   in_ready                   per-port buffer not full
//   out_pkt/out_port/out_valid granted packet, its source port, valid
//   out_ready                  routing core takes out_pkt this cycle
//   drop_count                 saturating count of words lost on full buffers
//   busy                       any buffer non-empty or out_valid
//
// Output stage FSM:
//   state     | meaning
//   OUT_EMPTY | output register holds nothing, out_valid=0
//   OUT_HOLD  | output register holds a packet, out_valid=1
module apo_port_arbiter_5_nodes #(
   parameter int N2     = 7,
   parameter int DEPTH  = 2,
   parameter int PORTS  = 5,
   parameter int DROP_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N2-1:0]     in_free,
   input  logic [N2-1:0]     in_r1R,
   input  logic [N2-1:0]     in_r2R,
   input  logic [N2-1:0]     in_r1L,
   input  logic [N2-1:0]     in_r2L,
   output logic [PORTS-1:0]  in_ready,
   output logic [N2-1:0]     out_pkt,
   output logic [2:0]        out_port,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DROP_W-1:0] drop_count,
   output logic              busy
);

   import apo_noc_pkg::*;

   logic [N2-1:0]     w_in_pkt  [PORTS];
   logic [N2-1:0]     w_head    [PORTS];
   logic [PORTS-1:0]  w_in_vld;
   logic [PORTS-1:0]  w_full;
   logic [PORTS-1:0]  w_empty;
   logic [PORTS-1:0]  w_pop;
   logic [PORTS-1:0]  w_drop;
   logic [2:0]        w_drop_n;
   logic [DROP_W:0]   w_drop_sum;
   logic              w_load;
   logic              w_any;
   logic [PORT_W-1:0] w_grant;
   out_state_e        r_state;
   out_state_e        w_state_nxt;
   logic [N2-1:0]     r_out_pkt;
   logic [PORT_W-1:0] r_out_port;
   logic [PORT_W-1:0] r_rr_ptr;
   logic [DROP_W-1:0] r_drop;

   assign w_in_pkt[PORT_FREE] = in_free;
   assign w_in_pkt[PORT_R1R]  = in_r1R;
   assign w_in_pkt[PORT_R2R]  = in_r2R;
   assign w_in_pkt[PORT_R1L]  = in_r1L;
   assign w_in_pkt[PORT_R2L]  = in_r2L;

   for (genvar g = 0; g < PORTS; g++) begin : g_port
      assign w_in_vld[g] = w_in_pkt[g][N2-1];
      assign w_drop[g]   = w_in_vld[g] & w_full[g] & ~w_pop[g];

      apo_port_fifo #(
         .W     (N2),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_push  (w_in_vld[g]),
         .i_pop   (w_pop[g]),
         .i_data  (w_in_pkt[g]),
         .o_data  (w_head[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g])
      );
   end

   assign w_load = (r_state == OUT_EMPTY) | out_ready;

   // Round-robin search: walk from the farthest offset down so the nearest
   // non-empty port to r_rr_ptr is the one left standing.
   always_comb begin
      int idx;
      w_any   = 1'b0;
      w_grant = '0;
      idx     = 0;
      for (int k = PORTS - 1; k >= 0; k--) begin
         idx = (int'(r_rr_ptr) + k) % PORTS;
         if (!w_empty[idx]) begin
            w_any   = 1'b1;
            w_grant = PORT_W'(idx);
         end
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < PORTS; i++) begin
         w_pop[i] = w_load & w_any & (w_grant == PORT_W'(i));
      end
   end

   always_comb begin
      w_drop_n = '0;
      for (int i = 0; i < PORTS; i++) begin
         w_drop_n = w_drop_n + {2'b00, w_drop[i]};
      end
   end

   assign w_drop_sum = {1'b0, r_drop} + (DROP_W + 1)'(w_drop_n);

   always_comb begin
      w_state_nxt = r_state;
      if (w_load) w_state_nxt = w_any ? OUT_HOLD : OUT_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= OUT_EMPTY;
         r_out_pkt  <= '0;
         r_out_port <= '0;
         r_rr_ptr   <= '0;
         r_drop     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load && w_any) begin
            r_out_pkt  <= w_head[w_grant];
            r_out_port <= w_grant;
            r_rr_ptr   <= (w_grant == PORT_W'(PORTS - 1)) ? '0 : w_grant + 1'b1;
         end
         r_drop <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
      end
   end

   assign in_ready   = ~w_full;
   assign out_pkt    = r_out_pkt;
   assign out_port   = r_out_port;
   assign out_valid  = (r_state == OUT_HOLD);
   assign drop_count = r_drop;
   assign busy       = out_valid | ~(&w_empty);

endmodule

// File: tb/tb_apo_port_arbiter_5_nodes.sv
module tb_apo_port_arbiter_5_nodes;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] in_free = '0, in_r1R = '0, in_r2R = '0, in_r1L = '0, in_r2L = '0;
   logic [4:0] in_ready;
   logic [6:0] out_pkt;
   logic [2:0] out_port;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] drop_count;
   logic       busy;

   int n_chk = 0;
   int n_fail = 0;

   apo_port_arbiter_5_nodes dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_free    (in_free),
      .in_r1R     (in_r1R),
      .in_r2R     (in_r2R),
      .in_r1L     (in_r1L),
      .in_r2L     (in_r2L),
      .in_ready   (in_ready),
      .out_pkt    (out_pkt),
      .out_port   (out_port),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .drop_count (drop_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [6:0] v);
      in_free = v; in_r1R = v; in_r2R = v; in_r1L = v; in_r2L = v;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [2:0] seq_port [5];
      seq_port = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

      // reset state
      tick();
      rst_n = 1'b1;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 5'b11111);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_count, 0);

      // async reset while buffers hold packets and out_valid=1
      set_all(7'h41);
      tick();
      set_all(7'h00);
      chk("t1_nolat_valid", out_valid, 0);
      chk("t1_busy_pre", busy, 1);
      tick();
      chk("t1_valid_pre", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("t1_rst_valid", out_valid, 0);
      chk("t1_rst_pkt", out_pkt, 0);
      chk("t1_rst_port", out_port, 0);
      chk("t1_rst_ready", in_ready, 5'b11111);
      chk("t1_rst_busy", busy, 0);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         tick();
         chk("t1_post_valid", out_valid, 0);
      end
      chk("t1_post_busy", busy, 0);

      // single packet on r2R, held while out_ready=0
      out_ready = 1'b0;
      in_r2R = 7'h4A;
      tick();
      in_r2R = 7'h00;
      chk("t2_edge0_valid", out_valid, 0);
      tick();
      chk("t2_valid", out_valid, 1);
      chk("t2_pkt", out_pkt, 7'h4A);
      chk("t2_port", out_port, 2);
      repeat (3) begin
         tick();
         chk("t2_hold_valid", out_valid, 1);
         chk("t2_hold_pkt", out_pkt, 7'h4A);
         chk("t2_hold_port", out_port, 2);
      end
      out_ready = 1'b1;
      tick();
      chk("t2_drain", out_valid, 0);

      // all five at once from rr_ptr=0
      pulse_reset();
      out_ready = 1'b1;
      in_free = 7'h40; in_r1R = 7'h41; in_r2R = 7'h42; in_r1L = 7'h43; in_r2L = 7'h44;
      tick();
      set_all(7'h00);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_valid", out_valid, 1);
         chk("t3_port", out_port, seq_port[i]);
         chk("t3_pkt", out_pkt, 7'h40 + i);
      end
      tick();
      chk("t3_end_valid", out_valid, 0);
      chk("t3_drop", drop_count, 0);
      // rr_ptr is 0 again: port 0 must beat port 4
      in_free = 7'h45; in_r2L = 7'h46;
      tick();
      set_all(7'h00);
      tick();
      chk("t3_rr0_port", out_port, 0);
      chk("t3_rr0_pkt", out_pkt, 7'h45);
      tick();
      chk("t3_rr1_port", out_port, 4);
      chk("t3_rr1_pkt", out_pkt, 7'h46);
      tick();
      chk("t3_rr_end", out_valid, 0);

      // r1L overflow with out_ready=0
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_r1L = 7'h50 + 7'(i);
         tick();
         if (i == 2) chk("t4_ready_full", in_ready, 5'b10111);
      end
      in_r1L = 7'h00;
      chk("t4_drop", drop_count, 1);
      chk("t4_pkt", out_pkt, 7'h50);
      chk("t4_port", out_port, 3);
      // pop and push on a full buffer: no drop
      out_ready = 1'b1;
      in_r1L = 7'h54;
      tick();
      in_r1L = 7'h00;
      chk("t4_pp_drop", drop_count, 1);
      chk("t4_pp_pkt", out_pkt, 7'h51);
      tick();
      chk("t4_pkt2", out_pkt, 7'h52);
      tick();
      chk("t4_pkt3", out_pkt, 7'h54);
      tick();
      chk("t4_empty", out_valid, 0);

      // drop counter saturation
      out_ready = 1'b0;
      in_free = 7'h60;
      repeat (300) tick();
      in_free = 7'h00;
      chk("t5_sat", drop_count, 8'hFF);
      chk("t5_ready0", in_ready[0], 0);
      out_ready = 1'b1;
      repeat (4) tick();
      chk("t5_drained", busy, 0);

      // invalid words change nothing
      set_all(7'h3F);
      repeat (10) tick();
      chk("t6_valid", out_valid, 0);
      chk("t6_drop", drop_count, 8'hFF);
      chk("t6_busy", busy, 0);
      chk("t6_ready", in_ready, 5'b11111);
      set_all(7'h00);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apo_port_arbiter_5_nodes.md
Name: apo_port_arbiter_5_nodes

Overview:
Input-side scheduler for the 5-node circulant C(5; 1, 2) router.
- Buffers packets arriving on the five router inputs: local IP port plus r1R, r2R, r1L, r2L.
- Shares the single routing datapath between them with round-robin arbitration.
- Presents one packet at a time to the routing core over a valid/ready handshake.
- Replaces the fixed-priority first-valid selection, which silently loses simultaneous arrivals; drops become counted overflow only.

Parameters:
N2, 7, packet width; bit N2-1 is the valid/emulation flag, the remaining bits are the payload.
DEPTH, 2, entries per input buffer (≥1).
PORTS, 5, number of arbitrated inputs (fixed at 5 for this topology).
DROP_W, 8, width of the saturating drop counter.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_free  in  N2  packet from local IP core (port index 0)
in_r1R  in  N2  packet from right, generator 1 (index 1)
in_r2R  in  N2  packet from right, generator 2 (index 2)
in_r1L  in  N2  packet from left, generator 1 (index 3)
in_r2L  in  N2  packet from left, generator 2 (index 4)
in_ready  out  PORTS  per-port buffer not full; bit i matches index i
out_pkt  out  N2  granted packet to routing core
out_port  out  3  index of the port out_pkt came from
out_valid  out  1  out_pkt valid
out_ready  in  1  routing core accepts out_pkt this cycle
drop_count  out  DROP_W  packets dropped on full buffers, saturating
busy  out  1  any buffer non-empty or out_valid

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-transfer):
  - All buffers are flushed.
  - out_pkt=0, out_port=0, out_valid=0, drop_count=0, rr_ptr=0, busy=0.
  - in_ready=5'b11111 (all buffers empty).
- Valid word: bit N2-1 == 1. Words with bit N2-1 == 0 are ignored and change no state.
- Per-port enqueue, each rising edge:
  - Valid word and count<DEPTH → push.
  - Valid word and count==DEPTH → drop; drop_count+1, saturating at 2^DROP_W-1.
  - Simultaneous pop and push on a full buffer: the pop frees a slot, so the push is accepted and no drop occurs.
- in_ready[i] = (count_i < DEPTH), derived from registered state only; no combinational path from out_ready.
- Output stage is one register with two states:
  - EMPTY (out_valid=0).
  - HOLD (out_valid=1).
- Load condition: out_valid==0 or out_ready==1.
  - If the condition holds and any buffer is non-empty, the arbiter picks the first non-empty port searching rr_ptr, rr_ptr+1, … mod 5.
  - On that edge: pop its head into out_pkt, set out_port, out_valid=1, rr_ptr ← (grant+1) mod 5.
  - If the condition holds and no buffer is non-empty: out_valid ← 0.
- HOLD with out_ready=0: out_pkt, out_port and rr_ptr are stable; no pop occurs.
- Throughput: one packet per cycle while out_ready=1.
- Minimum latency: valid word sampled at edge t → out_valid=1 after edge t+1. There is no bypass path.
- Fairness: a non-empty port waits at most 4 grants.
- The local port has no special priority.
- busy = out_valid | any buffer non-empty.
- Payload bits pass through unmodified; this block does no routing arithmetic.

Decomposition:
- Shared package apo_noc_pkg:
  - N2.
  - Valid-bit index.
  - Port index constants PORT_FREE=0, PORT_R1R=1, PORT_R2R=2, PORT_R1L=3, PORT_R2L=4.
  - Port-index width 3.
- Sub-module apo_port_fifo:
  - DEPTH-entry synchronous FIFO with push/pop/full/empty and async active-low reset.
  - Instantiated 5×.
- Arbiter and output register stay in the top module.

Test Plan:
1. Assert rst_n=0 while buffers hold packets and out_valid=1 → outputs immediately zero, in_ready=5'b11111, busy=0; after release nothing is emitted.
2. in_r2R=7'h4A (1_001_010) for one cycle at edge 0, out_ready=0 → after edge 1: out_valid=1, out_pkt=7'h4A, out_port=2; held unchanged for 3 cycles; out_ready=1 → out_valid=0 next edge.
3. All five inputs valid at edge 0 (payloads 0x40..0x44), out_ready=1 → out_port sequence 0,1,2,3,4 on consecutive cycles, payloads matching; rr_ptr back to 0; drop_count=0.
4. out_ready=0, in_r1L valid on 4 consecutive edges → first packet in output register, next two buffered, in_ready[3]=0 after third edge, fourth dropped, drop_count=1.
5. Hold port 0 full and keep driving valid words for 300 cycles with out_ready=0 → drop_count saturates at 8'hFF, no wrap.
6. Words 7'h3F on every input for 10 cycles → no enqueue, out_valid=0, drop_count unchanged, busy=0.
